// File: rtl/arb_6to1_rr_32b_pkg.sv
// Shared types and helpers for the 6-requester round-robin output arbiter.
package arb_6to1_rr_32b_pkg;

  localparam int unsigned ARB_N_REQ = 6;
  localparam int unsigned ARB_SEL_W = 3;
  localparam int unsigned ARB_SIZE  = 32;

  typedef logic [ARB_SEL_W-1:0] arb_sel_t;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // One registered output beat.
  typedef struct packed {
    logic                last;
    arb_sel_t            src;
    logic [ARB_SIZE-1:0] data;
  } arb_beat_t;

  // Wrapping increment over the requester indices 0..ARB_N_REQ-1.
  function automatic arb_sel_t rr_next(input arb_sel_t idx);
    return (idx >= arb_sel_t'(ARB_N_REQ - 1)) ? arb_sel_t'(0) : idx + arb_sel_t'(1);
  endfunction

endpackage

// File: rtl/arb_6to1_rr_32b_mux.sv
// 6:1 data mux for the arbiter data path; unused select codes yield zero.
module mux_6to1_32b
  import arb_6to1_rr_32b_pkg::*;
#(
  parameter int unsigned SIZE = ARB_SIZE
) (
  input  logic [ARB_SEL_W-1:0] select,
  input  logic [SIZE-1:0]      data0,
  input  logic [SIZE-1:0]      data1,
  input  logic [SIZE-1:0]      data2,
  input  logic [SIZE-1:0]      data3,
  input  logic [SIZE-1:0]      data4,
  input  logic [SIZE-1:0]      data5,
  output logic [SIZE-1:0]      dout_c
);

  always_comb begin
    dout_c = '0;
    case (select)
      3'd0:    dout_c = data0;
      3'd1:    dout_c = data1;
      3'd2:    dout_c = data2;
      3'd3:    dout_c = data3;
      3'd4:    dout_c = data4;
      3'd5:    dout_c = data5;
      default: dout_c = '0;
    endcase
  end

endmodule

// File: rtl/arb_6to1_rr_32b.sv
// Round-robin 6:1 arbiter with packet lock and a single registered output stage
// for a shared 32-bit CGRA output channel.
module arb_6to1_rr_32b
  import arb_6to1_rr_32b_pkg::*;
(
  input  logic                 CGRA_Clock,
  input  logic                 CGRA_Reset_n,
  input  logic                 CGRA_Enable,
  input  logic [ARB_N_REQ-1:0] in_valid,
  input  logic [ARB_N_REQ-1:0] in_last,
  input  logic [ARB_SIZE-1:0]  in_data0,
  input  logic [ARB_SIZE-1:0]  in_data1,
  input  logic [ARB_SIZE-1:0]  in_data2,
  input  logic [ARB_SIZE-1:0]  in_data3,
  input  logic [ARB_SIZE-1:0]  in_data4,
  input  logic [ARB_SIZE-1:0]  in_data5,
  output logic [ARB_N_REQ-1:0] in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ARB_SIZE-1:0]  out_data,
  output logic                 out_last,
  output logic [ARB_SEL_W-1:0] out_src
);

  localparam int unsigned SIZE  = ARB_SIZE;
  localparam int unsigned N_REQ = ARB_N_REQ;

  arb_state_e           state_q, state_d;
  arb_sel_t             ptr_q, ptr_d;
  arb_sel_t             gsel_q, gsel_d;
  logic                 out_valid_q, out_valid_d;
  arb_beat_t            beat_q, beat_d;

  logic [N_REQ-1:0]     rot_c;
  arb_sel_t             scan_off_c;
  logic                 scan_hit_c;
  arb_sel_t             scan_idx_c;
  arb_sel_t             cand_c;
  logic                 cand_vld_c;
  logic                 can_load_c;
  logic                 accept_c;
  logic [SIZE-1:0]      mux_data_c;

  // Rotate in_valid so that bit 0 corresponds to the current priority pointer.
  always_comb begin
    logic [3:0] rot_idx;
    rot_c   = '0;
    rot_idx = '0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      rot_idx = 4'(ptr_q) + 4'(j);
      if (rot_idx >= 4'(N_REQ)) rot_idx = rot_idx - 4'(N_REQ);
      rot_c[j] = in_valid[rot_idx[2:0]];
    end
  end

  // Fixed-priority pick on the rotated vector, then map back to an absolute index.
  always_comb begin
    logic [3:0] abs_idx;
    scan_hit_c = 1'b0;
    scan_off_c = '0;
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (rot_c[j]) begin
        scan_hit_c = 1'b1;
        scan_off_c = arb_sel_t'(j);
      end
    end
    abs_idx = 4'(ptr_q) + 4'(scan_off_c);
    if (abs_idx >= 4'(N_REQ)) abs_idx = abs_idx - 4'(N_REQ);
    scan_idx_c = abs_idx[2:0];
  end

  // A locked packet keeps its requester even when other ports are waiting.
  always_comb begin
    cand_c     = scan_idx_c;
    cand_vld_c = scan_hit_c;
    if (state_q == ST_LOCKED) begin
      cand_c     = gsel_q;
      cand_vld_c = in_valid[gsel_q];
    end
  end

  assign can_load_c = CGRA_Reset_n & CGRA_Enable & (~out_valid_q | out_ready);
  assign accept_c   = can_load_c & cand_vld_c;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      in_ready[i] = accept_c & (cand_c == arb_sel_t'(i));
    end
  end

  mux_6to1_32b #(
    .SIZE (SIZE)
  ) u_mux (
    .select (cand_c),
    .data0  (in_data0),
    .data1  (in_data1),
    .data2  (in_data2),
    .data3  (in_data3),
    .data4  (in_data4),
    .data5  (in_data5),
    .dout_c (mux_data_c)
  );

  // Next state: lock on non-last beats, advance the pointer past the winner on last.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gsel_d      = gsel_q;
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      beat_d      = '{last: in_last[cand_c], src: cand_c, data: mux_data_c};
      if (in_last[cand_c]) begin
        state_d = ST_FREE;
        ptr_d   = rr_next(cand_c);
      end else begin
        state_d = ST_LOCKED;
        gsel_d  = cand_c;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
    if (!CGRA_Reset_n) begin
      state_q     <= ST_FREE;
      ptr_q       <= '0;
      gsel_q      <= '0;
      out_valid_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gsel_q      <= gsel_d;
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = beat_q.data;
  assign out_last  = beat_q.last;
  assign out_src   = beat_q.src;

endmodule

// File: tb/tb_arb_6to1_rr_32b.sv
// Directed self-checking bench for arb_6to1_rr_32b.
module tb_arb_6to1_rr_32b;
  import arb_6to1_rr_32b_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [ARB_N_REQ-1:0] vld;
  logic [ARB_N_REQ-1:0] lst;
  logic [31:0]          din [ARB_N_REQ];
  logic [ARB_N_REQ-1:0] rdy;
  logic                 ov;
  logic                 ordy;
  logic [31:0]          od;
  logic                 ol;
  logic [ARB_SEL_W-1:0] osrc;

  int n_checks = 0;
  int n_fail   = 0;

  arb_6to1_rr_32b dut (
    .CGRA_Clock   (clk),
    .CGRA_Reset_n (rst_n),
    .CGRA_Enable  (en),
    .in_valid     (vld),
    .in_last      (lst),
    .in_data0     (din[0]),
    .in_data1     (din[1]),
    .in_data2     (din[2]),
    .in_data3     (din[3]),
    .in_data4     (din[4]),
    .in_data5     (din[5]),
    .in_ready     (rdy),
    .out_valid    (ov),
    .out_ready    (ordy),
    .out_data     (od),
    .out_last     (ol),
    .out_src      (osrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    ordy  = 1'b1;
    vld   = 6'h3F;
    lst   = 6'h3F;
    for (int i = 0; i < 6; i++) din[i] = 32'hA0 + 32'(i);

    // Reset held with every requester valid.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(rdy), 32'h0);
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_data", od, 32'h0);
    chk("rst_src", 32'(osrc), 32'h0);
    chk("rst_last", 32'(ol), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("first_grant", 32'(rdy), 32'h01);

    // Fair rotation with single-beat packets.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
      chk("rr_valid", 32'(ov), 32'h1);
      chk("rr_data", od, 32'hA0 + 32'(k % 6));
      chk("rr_src", 32'(osrc), 32'(k % 6));
      if (k == 6) begin
        vld    = 6'b010100;
        lst    = 6'b010000;
        din[2] = 32'h201;
        din[4] = 32'h400;
      end
      #1;
      if (k < 6) chk("rr_ready", 32'(rdy), 32'h1 << ((k + 1) % 6));
      else       chk("pkt_ready1", 32'(rdy), 32'b000100);
    end

    // Three-beat packet from requester 2 while 4 waits.
    @(negedge clk); #1;
    chk("pkt_data1", od, 32'h201);
    chk("pkt_last1", 32'(ol), 32'h0);
    chk("pkt_src1", 32'(osrc), 32'h2);
    din[2] = 32'h202;
    #1;
    chk("pkt_ready2", 32'(rdy), 32'b000100);

    @(negedge clk); #1;
    chk("pkt_data2", od, 32'h202);
    chk("pkt_src2", 32'(osrc), 32'h2);
    din[2] = 32'h203;
    lst    = 6'b010100;
    #1;
    chk("pkt_ready3", 32'(rdy), 32'b000100);

    @(negedge clk); #1;
    chk("pkt_data3", od, 32'h203);
    chk("pkt_last3", 32'(ol), 32'h1);
    chk("pkt_src3", 32'(osrc), 32'h2);
    #1;
    chk("after_pkt_ready", 32'(rdy), 32'b010000);

    @(negedge clk); #1;
    chk("r4_data", od, 32'h400);
    chk("r4_src", 32'(osrc), 32'h4);
    vld = '0;
    #1;
    chk("idle_ready", 32'(rdy), 32'h0);

    // Backpressure: hold a beat for four stalled cycles.
    @(negedge clk); #1;
    chk("drain_valid", 32'(ov), 32'h0);
    vld    = 6'b000010;
    lst    = 6'h3F;
    din[1] = 32'h111;
    #1;
    chk("bp_ready0", 32'(rdy), 32'b000010);

    @(negedge clk); #1;
    chk("bp_data0", od, 32'h111);
    chk("bp_src0", 32'(osrc), 32'h1);
    ordy   = 1'b0;
    din[1] = 32'h222;
    #1;
    chk("bp_stall_ready", 32'(rdy), 32'h0);

    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      chk("bp_hold_data", od, 32'h111);
      chk("bp_hold_valid", 32'(ov), 32'h1);
      if (b == 3) ordy = 1'b1;
      #1;
      chk("bp_hold_ready", 32'(rdy), (b == 3) ? 32'b000010 : 32'h0);
    end

    @(negedge clk); #1;
    chk("bp_reload_data", od, 32'h222);
    chk("bp_reload_valid", 32'(ov), 32'h1);
    vld    = 6'b001010;
    din[3] = 32'h333;
    #1;
    chk("ptr2_picks3", 32'(rdy), 32'b001000);

    // Pointer wrap from requester 5 back to 0.
    @(negedge clk); #1;
    chk("r3_src", 32'(osrc), 32'h3);
    chk("r3_data", od, 32'h333);
    vld    = 6'b100001;
    din[5] = 32'h555;
    #1;
    chk("ptr4_picks5", 32'(rdy), 32'b100000);

    @(negedge clk); #1;
    chk("r5_src", 32'(osrc), 32'h5);
    chk("r5_data", od, 32'h555);
    #1;
    chk("wrap_picks0", 32'(rdy), 32'b000001);

    // Enable low blocks accepts but still lets the output drain.
    @(negedge clk); #1;
    chk("r0_src", 32'(osrc), 32'h0);
    en  = 1'b0;
    vld = 6'b000001;
    #1;
    chk("dis_ready", 32'(rdy), 32'h0);

    @(negedge clk); #1;
    chk("dis_drain", 32'(ov), 32'h0);
    en     = 1'b1;
    vld    = 6'b000100;
    lst    = 6'h00;
    din[2] = 32'h2A2;
    #1;
    chk("lock_ready", 32'(rdy), 32'b000100);

    // Reset in the middle of a locked packet.
    @(negedge clk); #1;
    chk("lock_valid", 32'(ov), 32'h1);
    chk("lock_data", od, 32'h2A2);
    chk("lock_last", 32'(ol), 32'h0);
    vld   = 6'b000101;
    lst   = 6'h3F;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov), 32'h0);
    chk("midrst_data", od, 32'h0);
    chk("midrst_src", 32'(osrc), 32'h0);
    chk("midrst_ready", 32'(rdy), 32'h0);

    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", 32'(rdy), 32'b000001);

    @(negedge clk); #1;
    chk("postrst_src", 32'(osrc), 32'h0);
    chk("postrst_data", od, 32'hA0);
    chk("postrst_last", 32'(ol), 32'h1);
    vld = '0;
    #1;
    chk("end_ready", 32'(rdy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
